// File: rtl/avalon_switch_poller.sv
// Avalon-MM poller for the slide-switch PIO: periodic reads of data register 0,
// debounce over STABLE_CNT identical samples, sticky change flags and interrupt.
module avalon_switch_poller #(
  parameter int DATA_W       = 18,
  parameter int POLL_DIV     = 50000,
  parameter int STABLE_CNT   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              cap_clear,
  input  logic [DATA_W-1:0] cap_clear_mask,
  output logic [DATA_W-1:0] sw_state,
  output logic [DATA_W-1:0] sw_changed,
  output logic              irq,
  output logic              sample_tick
);

  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int LW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_DIV - 1);
  localparam logic [PW-1:0] POLL_ONE  = PW'(1);
  localparam logic [LW-1:0] LAT_LOAD  = LW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [LW-1:0] LAT_ONE   = LW'(1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CNT);
  localparam logic [SW-1:0] STAB_ONE  = SW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    LAT    = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [PW-1:0]     poll_cnt_r, poll_cnt_s;
  logic [LW-1:0]     lat_cnt_r, lat_cnt_s;
  logic [DATA_W-1:0] cand_r, sample_s, set_mask_s, clr_mask_s, changed_s;
  logic [SW-1:0]     stab_r, stab_s;
  logic              commit_s;
  logic              unused_readdata_s;

  assign avm_address       = 2'd0;
  assign unused_readdata_s = ^avm_readdata[31:DATA_W];

  // Next-state and counter logic; a started transaction always runs to SAMPLE
  always_comb begin
    state_s    = state_r;
    poll_cnt_s = poll_cnt_r;
    lat_cnt_s  = lat_cnt_r;
    case (state_r)
      IDLE: begin
        if (!enable) begin
          poll_cnt_s = POLL_LOAD;
        end else if (poll_cnt_r == {PW{1'b0}}) begin
          state_s = ISSUE;
        end else begin
          poll_cnt_s = poll_cnt_r - POLL_ONE;
        end
      end
      ISSUE: begin
        if (avm_waitrequest) begin
          state_s = ISSUE;
        end else if (READ_LATENCY > 1) begin
          state_s   = LAT;
          lat_cnt_s = LAT_LOAD;
        end else begin
          state_s = SAMPLE;
        end
      end
      LAT: begin
        if (lat_cnt_r == {LW{1'b0}}) begin
          state_s = SAMPLE;
        end else begin
          lat_cnt_s = lat_cnt_r - LAT_ONE;
        end
      end
      SAMPLE: begin
        state_s    = IDLE;
        poll_cnt_s = POLL_LOAD;
      end
      default: begin
        state_s    = IDLE;
        poll_cnt_s = POLL_LOAD;
      end
    endcase
  end

  // FSM register; avm_read and sample_tick are registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      poll_cnt_r  <= POLL_LOAD;
      lat_cnt_r   <= {LW{1'b0}};
      avm_read    <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      state_r     <= state_s;
      poll_cnt_r  <= poll_cnt_s;
      lat_cnt_r   <= lat_cnt_s;
      avm_read    <= (state_s == ISSUE);
      sample_tick <= (state_s == SAMPLE);
    end
  end

  // Debounce update; a commit's set mask overrides a same-cycle clear
  always_comb begin
    sample_s = avm_readdata[DATA_W-1:0];
    if (sample_s != cand_r) begin
      stab_s = STAB_ONE;
    end else if (stab_r < STAB_MAX) begin
      stab_s = stab_r + STAB_ONE;
    end else begin
      stab_s = stab_r;
    end
    commit_s   = (state_r == SAMPLE) && (stab_s == STAB_MAX) && (stab_r < STAB_MAX);
    set_mask_s = commit_s ? (sample_s ^ sw_state) : {DATA_W{1'b0}};
    clr_mask_s = cap_clear ? cap_clear_mask : {DATA_W{1'b0}};
    changed_s  = (sw_changed & ~clr_mask_s) | set_mask_s;
  end

  // Debounce, published state, change flags and interrupt registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_r     <= {DATA_W{1'b0}};
      stab_r     <= {SW{1'b0}};
      sw_state   <= {DATA_W{1'b0}};
      sw_changed <= {DATA_W{1'b0}};
      irq        <= 1'b0;
    end else begin
      if (state_r == SAMPLE) begin
        cand_r <= sample_s;
        stab_r <= stab_s;
      end else begin
        cand_r <= cand_r;
        stab_r <= stab_r;
      end
      if (commit_s) begin
        sw_state <= sample_s;
      end else begin
        sw_state <= sw_state;
      end
      sw_changed <= changed_s;
      irq        <= |sw_changed;
    end
  end

endmodule

// File: tb/tb_avalon_switch_poller.sv
// Directed self-checking bench for avalon_switch_poller (POLL_DIV=4, STABLE_CNT=3,
// READ_LATENCY=1): cadence, debounce, clear/set priority, waitrequest and reset.
module tb_avalon_switch_poller;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        cap_clear;
  logic [17:0] cap_clear_mask;
  logic [17:0] sw_state;
  logic [17:0] sw_changed;
  logic        irq;
  logic        sample_tick;

  int total;
  int passed;
  int cnt_a;
  int cnt_b;
  int first_idx;

  avalon_switch_poller #(
    .DATA_W(18), .POLL_DIV(4), .STABLE_CNT(3), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .cap_clear(cap_clear), .cap_clear_mask(cap_clear_mask),
    .sw_state(sw_state), .sw_changed(sw_changed),
    .irq(irq), .sample_tick(sample_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive d, wait for the SAMPLE cycle, optionally clear on its ending edge, step past it
  task automatic sample_with(input logic [31:0] d, input logic clr, input logic [17:0] mask);
    int n;
    n = 0;
    avm_readdata = d;
    while (sample_tick !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("sample_wait", {31'd0, sample_tick}, 32'd1);
    cap_clear      = clr;
    cap_clear_mask = mask;
    tick();
    cap_clear      = 1'b0;
    cap_clear_mask = 18'd0;
  endtask

  task automatic clear_all();
    cap_clear      = 1'b1;
    cap_clear_mask = 18'h3FFFF;
    tick();
    cap_clear      = 1'b0;
    cap_clear_mask = 18'd0;
  endtask

  initial begin
    total = 0; passed = 0;
    reset = 1'b1; enable = 1'b0; avm_waitrequest = 1'b0;
    avm_readdata = 32'd0; cap_clear = 1'b0; cap_clear_mask = 18'd0;
    tick(); tick();
    reset = 1'b0;

    // Reset / idle with polling disabled
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt_a += int'(avm_read) + int'(sample_tick);
    end
    chk("idle_no_read", cnt_a, 32'd0);
    chk("idle_sw_state", sw_state, 32'd0);
    chk("idle_sw_changed", sw_changed, 32'd0);
    chk("idle_irq", irq, 32'd0);
    chk("idle_address", avm_address, 32'd0);

    // Poll cadence from a fresh reset
    reset = 1'b1; tick();
    reset = 1'b0; enable = 1'b1;
    tick(); tick(); tick();
    chk("cad_no_early_read", avm_read, 32'd0);
    tick();
    chk("cad_first_read", avm_read, 32'd1);
    tick();
    chk("cad_read_drop", avm_read, 32'd0);
    chk("cad_tick_after_read", sample_tick, 32'd1);
    cnt_a = 0; cnt_b = 0; first_idx = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (avm_read === 1'b1 && first_idx == 0) first_idx = i;
      cnt_a += int'(avm_read);
      cnt_b += int'(sample_tick);
    end
    chk("cad_period_first", first_idx, 32'd5);
    chk("cad_read_count", cnt_a, 32'd2);
    chk("cad_tick_count", cnt_b, 32'd2);

    // Debounce commit, upper readdata bits ignored
    reset = 1'b1; tick();
    reset = 1'b0;
    sample_with(32'hFFFC0005, 1'b0, 18'd0);
    sample_with(32'hFFFC0005, 1'b0, 18'd0);
    chk("deb_no_commit_2", sw_state, 32'd0);
    sample_with(32'hFFFC0005, 1'b0, 18'd0);
    chk("deb_commit_state", sw_state, 32'h5);
    chk("deb_commit_changed", sw_changed, 32'h5);
    chk("deb_irq_lag", irq, 32'd0);
    tick();
    chk("deb_irq", irq, 32'd1);

    // Bounce rejection
    clear_all();
    chk("clr_all", sw_changed, 32'd0);
    sample_with(32'h1, 1'b0, 18'd0);
    sample_with(32'h0, 1'b0, 18'd0);
    chk("bnc_hold_2", sw_state, 32'h5);
    sample_with(32'h1, 1'b0, 18'd0);
    sample_with(32'h1, 1'b0, 18'd0);
    chk("bnc_hold_4", sw_state, 32'h5);
    sample_with(32'h1, 1'b0, 18'd0);
    chk("bnc_commit_state", sw_state, 32'h1);
    chk("bnc_commit_changed", sw_changed, 32'h4);

    // Clear vs set on the same edge
    clear_all();
    sample_with(32'h2, 1'b0, 18'd0);
    sample_with(32'h2, 1'b0, 18'd0);
    sample_with(32'h2, 1'b0, 18'd0);
    chk("cs_changed_3", sw_changed, 32'h3);
    sample_with(32'h3, 1'b0, 18'd0);
    sample_with(32'h3, 1'b0, 18'd0);
    sample_with(32'h3, 1'b1, 18'h3);
    chk("cs_set_wins", sw_changed, 32'h1);
    chk("cs_state", sw_state, 32'h3);
    chk("cs_irq_now", irq, 32'd1);
    tick();
    chk("cs_irq_held", irq, 32'd1);
    cap_clear = 1'b1; cap_clear_mask = 18'h1;
    tick();
    cap_clear = 1'b0; cap_clear_mask = 18'd0;
    chk("cs_clear_only", sw_changed, 32'd0);
    tick();
    chk("cs_irq_drop", irq, 32'd0);

    // Waitrequest stall with enable dropped mid-transaction
    avm_waitrequest = 1'b1;
    cnt_a = 0;
    while (avm_read !== 1'b1 && cnt_a < 20) begin
      tick();
      cnt_a++;
    end
    chk("wr_read_start", avm_read, 32'd1);
    enable = 1'b0;
    cnt_b = 1;
    tick(); cnt_b += int'(avm_read);
    tick(); cnt_b += int'(avm_read);
    tick(); cnt_b += int'(avm_read);
    avm_waitrequest = 1'b0;
    tick();
    chk("wr_read_cycles", cnt_b, 32'd4);
    chk("wr_read_drop", avm_read, 32'd0);
    chk("wr_sample", sample_tick, 32'd1);
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt_a += int'(avm_read) + int'(sample_tick);
    end
    chk("wr_parked", cnt_a, 32'd0);
    chk("wr_state_kept", sw_state, 32'h3);

    // Reset while stalled
    enable = 1'b1; avm_waitrequest = 1'b1;
    cnt_a = 0;
    while (avm_read !== 1'b1 && cnt_a < 20) begin
      tick();
      cnt_a++;
    end
    chk("rs_stalled", avm_read, 32'd1);
    reset = 1'b1;
    tick();
    chk("rs_read_clear", avm_read, 32'd0);
    chk("rs_state_clear", sw_state, 32'd0);
    reset = 1'b0; enable = 1'b0; avm_waitrequest = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
